// File: rtl/multi_lane_stage_reg.sv
// Multi-issue inter-stage pipeline register: per-lane valid/kill, global flush,
// bubble/hold from the pause vector, younger-lane squash, saturating perf counters.
module multi_lane_stage_reg #(
    parameter int LANES          = 2,
    parameter int LANE_W         = 128,
    parameter int STAGE_IDX      = 4,
    parameter int PAUSE_W        = 8,
    parameter bit ZERO_ON_BUBBLE = 1'b1,
    parameter int CNT_W          = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [PAUSE_W-1:0]        pause,
    input  logic                      exception_flush,
    input  logic [LANES*LANE_W-1:0]   in_data,
    input  logic [LANES-1:0]          in_valid,
    input  logic [LANES-1:0]          in_kill,
    input  logic [LANES-1:0]          squash_lanes,
    output logic [LANES*LANE_W-1:0]   out_data,
    output logic [LANES-1:0]          out_valid,
    output logic [CNT_W-1:0]          stall_cnt,
    output logic [CNT_W-1:0]          bubble_cnt
);

    if (PAUSE_W < STAGE_IDX + 2) begin : g_bad_pause_w
        $error("multi_lane_stage_reg: PAUSE_W must be >= STAGE_IDX+2");
    end
    if (LANES < 1) begin : g_bad_lanes
        $error("multi_lane_stage_reg: LANES must be >= 1");
    end

    logic                    up;
    logic                    dn;
    logic                    unused_pause;

    logic [LANES*LANE_W-1:0] data_d,   data_q;
    logic [LANES-1:0]        valid_d,  valid_q;
    logic [CNT_W-1:0]        stall_d,  stall_q;
    logic [CNT_W-1:0]        bubble_d, bubble_q;

    assign up           = pause[STAGE_IDX];
    assign dn           = pause[STAGE_IDX+1];
    assign unused_pause = ^pause;

    always_comb begin
        data_d   = data_q;
        valid_d  = valid_q;
        stall_d  = stall_q;
        bubble_d = bubble_q;

        if (exception_flush) begin
            valid_d = '0;
            if (ZERO_ON_BUBBLE) data_d = '0;
        end else if (up && !dn) begin
            valid_d = '0;
            if (ZERO_ON_BUBBLE) data_d = '0;
            if (bubble_q != {CNT_W{1'b1}}) bubble_d = bubble_q + 1'b1;
        end else if (!up) begin
            for (int i = 0; i < LANES; i++) begin
                valid_d[i] = in_valid[i] & ~in_kill[i];
                if (ZERO_ON_BUBBLE && !valid_d[i]) begin
                    data_d[i*LANE_W +: LANE_W] = '0;
                end else begin
                    data_d[i*LANE_W +: LANE_W] = in_data[i*LANE_W +: LANE_W];
                end
            end
        end else begin
            // Stall is judged on what the stage held before this edge, not after squash.
            for (int i = 0; i < LANES; i++) begin
                if (squash_lanes[i]) begin
                    valid_d[i] = 1'b0;
                    if (ZERO_ON_BUBBLE) data_d[i*LANE_W +: LANE_W] = '0;
                end
            end
            if ((|valid_q) && (stall_q != {CNT_W{1'b1}})) stall_d = stall_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q   <= '0;
            valid_q  <= '0;
            stall_q  <= '0;
            bubble_q <= '0;
        end else begin
            data_q   <= data_d;
            valid_q  <= valid_d;
            stall_q  <= stall_d;
            bubble_q <= bubble_d;
        end
    end

    assign out_data   = data_q;
    assign out_valid  = valid_q;
    assign stall_cnt  = stall_q;
    assign bubble_cnt = bubble_q;

endmodule

// File: tb/tb_multi_lane_stage_reg.sv
// Directed bench for multi_lane_stage_reg: default instance, payload-holding
// instance (ZERO_ON_BUBBLE=0) and a narrow-counter instance for saturation.
module tb_multi_lane_stage_reg;

    logic         clk;
    logic         rst;
    logic [7:0]   pause;
    logic         exception_flush;
    logic [255:0] in_data;
    logic [1:0]   in_valid;
    logic [1:0]   in_kill;
    logic [1:0]   squash_lanes;

    logic [255:0] out_data,   nz_data,   s4_data;
    logic [1:0]   out_valid,  nz_valid,  s4_valid;
    logic [31:0]  stall_cnt,  bubble_cnt, nz_stall, nz_bubble;
    logic [3:0]   s4_stall,   s4_bubble;

    int n_cmp = 0;
    int n_mis = 0;

    multi_lane_stage_reg dut (
        .clk(clk), .rst(rst), .pause(pause), .exception_flush(exception_flush),
        .in_data(in_data), .in_valid(in_valid), .in_kill(in_kill), .squash_lanes(squash_lanes),
        .out_data(out_data), .out_valid(out_valid), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    multi_lane_stage_reg #(.ZERO_ON_BUBBLE(1'b0)) dut_nz (
        .clk(clk), .rst(rst), .pause(pause), .exception_flush(exception_flush),
        .in_data(in_data), .in_valid(in_valid), .in_kill(in_kill), .squash_lanes(squash_lanes),
        .out_data(nz_data), .out_valid(nz_valid), .stall_cnt(nz_stall), .bubble_cnt(nz_bubble)
    );

    multi_lane_stage_reg #(.CNT_W(4)) dut_s4 (
        .clk(clk), .rst(rst), .pause(pause), .exception_flush(exception_flush),
        .in_data(in_data), .in_valid(in_valid), .in_kill(in_kill), .squash_lanes(squash_lanes),
        .out_data(s4_data), .out_valid(s4_valid), .stall_cnt(s4_stall), .bubble_cnt(s4_bubble)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [255:0] D_AB = {128'hB, 128'hA};
    localparam logic [255:0] D_A0 = {128'h0, 128'hA};
    localparam logic [255:0] D_12 = {128'h2, 128'h1};
    localparam logic [255:0] D_CD = {128'hD, 128'hC};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; pause = '0; exception_flush = 1'b0; in_data = D_AB;
        in_valid = 2'b11; in_kill = '0; squash_lanes = '0;
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 2'b00) begin n_mis++; $display("FAIL reset_valid: got %b want 00", out_valid); end
        n_cmp++; if (out_data !== '0) begin n_mis++; $display("FAIL reset_data: got %h want 0", out_data); end
        n_cmp++; if (stall_cnt !== 0 || bubble_cnt !== 0) begin n_mis++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, bubble_cnt); end
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_load();
        pause = '0; in_valid = 2'b11; in_kill = '0; in_data = D_AB;
        step();
        n_cmp++; if (out_valid !== 2'b11) begin n_mis++; $display("FAIL load_valid: got %b want 11", out_valid); end
        n_cmp++; if (out_data !== D_AB) begin n_mis++; $display("FAIL load_data: got %h want %h", out_data, D_AB); end
    endtask

    task automatic test_kill();
        in_kill = 2'b10;
        step();
        n_cmp++; if (out_valid !== 2'b01) begin n_mis++; $display("FAIL kill_valid: got %b want 01", out_valid); end
        n_cmp++; if (out_data !== D_A0) begin n_mis++; $display("FAIL kill_data: got %h want %h", out_data, D_A0); end
        n_cmp++; if (nz_data !== D_AB || nz_valid !== 2'b01) begin n_mis++; $display("FAIL kill_nz: got %h/%b want %h/01", nz_data, nz_valid, D_AB); end
        in_kill = '0;
    endtask

    task automatic test_hold();
        step();
        pause = 8'h30; in_data = D_12;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (out_valid !== 2'b11 || out_data !== D_AB) begin n_mis++; $display("FAIL hold_out[%0d]: got %h/%b want %h/11", i, out_data, out_valid, D_AB); end
        end
        n_cmp++; if (stall_cnt !== 3) begin n_mis++; $display("FAIL hold_stall: got %0d want 3", stall_cnt); end
        n_cmp++; if (bubble_cnt !== 0) begin n_mis++; $display("FAIL hold_bubble: got %0d want 0", bubble_cnt); end
    endtask

    task automatic test_bubble();
        pause = 8'h10;
        step();
        n_cmp++; if (out_valid !== 2'b00 || out_data !== '0) begin n_mis++; $display("FAIL bubble_out: got %h/%b want 0/00", out_data, out_valid); end
        n_cmp++; if (bubble_cnt !== 1 || stall_cnt !== 3) begin n_mis++; $display("FAIL bubble_cnt: got b%0d s%0d want b1 s3", bubble_cnt, stall_cnt); end
        n_cmp++; if (nz_valid !== 2'b00 || nz_data !== D_AB) begin n_mis++; $display("FAIL bubble_nz: got %h/%b want %h/00", nz_data, nz_valid, D_AB); end
        pause = '0; in_data = D_AB;
        step();
        n_cmp++; if (out_valid !== 2'b11 || out_data !== D_AB) begin n_mis++; $display("FAIL bubble_restore: got %h/%b want %h/11", out_data, out_valid, D_AB); end
    endtask

    task automatic test_flush();
        exception_flush = 1'b1; pause = '0; in_valid = 2'b11; in_data = D_CD;
        step();
        n_cmp++; if (out_valid !== 2'b00 || out_data !== '0) begin n_mis++; $display("FAIL flush_out: got %h/%b want 0/00", out_data, out_valid); end
        n_cmp++; if (stall_cnt !== 3 || bubble_cnt !== 1) begin n_mis++; $display("FAIL flush_cnt: got s%0d b%0d want s3 b1", stall_cnt, bubble_cnt); end
        pause = 8'h10;
        step();
        n_cmp++; if (bubble_cnt !== 1) begin n_mis++; $display("FAIL flush_over_bubble: got b%0d want b1", bubble_cnt); end
        exception_flush = 1'b0;
    endtask

    task automatic test_squash();
        pause = '0; in_data = D_AB; in_valid = 2'b11; squash_lanes = 2'b10;
        step();
        n_cmp++; if (out_valid !== 2'b11) begin n_mis++; $display("FAIL squash_on_load: got %b want 11", out_valid); end
        pause = 8'h30;
        step();
        n_cmp++; if (out_valid !== 2'b01 || out_data !== D_A0) begin n_mis++; $display("FAIL squash_hold: got %h/%b want %h/01", out_data, out_valid, D_A0); end
        n_cmp++; if (stall_cnt !== 4) begin n_mis++; $display("FAIL squash_stall: got %0d want 4", stall_cnt); end
        n_cmp++; if (nz_valid !== 2'b01 || nz_data !== D_AB) begin n_mis++; $display("FAIL squash_nz: got %h/%b want %h/01", nz_data, nz_valid, D_AB); end
        squash_lanes = '0;
    endtask

    task automatic test_async_reset();
        step();
        n_cmp++; if (stall_cnt !== 5) begin n_mis++; $display("FAIL pre_reset_stall: got %0d want 5", stall_cnt); end
        #2 rst = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 2'b00 || out_data !== '0) begin n_mis++; $display("FAIL async_out: got %h/%b want 0/00", out_data, out_valid); end
        n_cmp++; if (stall_cnt !== 0 || bubble_cnt !== 0) begin n_mis++; $display("FAIL async_cnt: got s%0d b%0d want 0/0", stall_cnt, bubble_cnt); end
        @(negedge clk);
        rst = 1'b1;
        step();
        n_cmp++; if (out_valid !== 2'b00 || stall_cnt !== 0) begin n_mis++; $display("FAIL post_reset_hold: got %b s%0d want 00 s0", out_valid, stall_cnt); end
    endtask

    task automatic test_saturate();
        pause = '0; in_valid = 2'b11; in_data = D_AB;
        step();
        pause = 8'h30;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 14) begin
                n_cmp++; if (s4_stall !== 4'd14) begin n_mis++; $display("FAIL sat_pre: got %0d want 14", s4_stall); end
            end
        end
        n_cmp++; if (s4_stall !== 4'd15) begin n_mis++; $display("FAIL sat_stall: got %0d want 15", s4_stall); end
        n_cmp++; if (stall_cnt !== 20) begin n_mis++; $display("FAIL wide_stall: got %0d want 20", stall_cnt); end
        n_cmp++; if (s4_bubble !== 4'd0) begin n_mis++; $display("FAIL sat_bubble: got %0d want 0", s4_bubble); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_kill();
        test_hold();
        test_bubble();
        test_flush();
        test_squash();
        test_async_reset();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
